// File: rtl/mod_updown_counter.sv
// mod_updown_counter: synchronous up/down counter with programmable modulus,
// parallel load, synchronous clear, wrap-or-saturate boundary handling, and
// terminal-count, wrap-pulse and sticky-overflow status.
module mod_updown_counter #(
    parameter int WIDTH       = 4,
    parameter int MAX_COUNT   = 15,
    parameter int RESET_VALUE = 0,
    parameter int SATURATE    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    // Reject parameter combinations that would let count leave 0..MAX_COUNT.
    if (WIDTH < 1) begin : g_bad_width
        $error("mod_updown_counter: WIDTH must be >= 1");
    end
    if (MAX_COUNT < 1 || longint'(MAX_COUNT) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("mod_updown_counter: MAX_COUNT must be in 1..2^WIDTH-1");
    end
    if (RESET_VALUE < 0 || RESET_VALUE > MAX_COUNT) begin : g_bad_rst
        $error("mod_updown_counter: RESET_VALUE must be in 0..MAX_COUNT");
    end

    localparam logic [WIDTH-1:0] C_MAX = MAX_COUNT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] C_RST = RESET_VALUE[WIDTH-1:0];
    localparam logic             C_SAT = (SATURATE != 0);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_ovf;

    logic [WIDTH-1:0] w_next;
    logic             w_bnd;
    logic             w_at_top;
    logic             w_at_bot;

    // Out-of-range load values are pinned to the top of the count range.
    function automatic logic [WIDTH-1:0] f_clamp(input logic [WIDTH-1:0] v);
        return (v > C_MAX) ? C_MAX : v;
    endfunction

    assign w_at_top = (r_count == C_MAX);
    assign w_at_bot = (r_count == '0);

    // Next count and boundary detection; clear beats load beats counting.
    always_comb begin
        w_next = r_count;
        w_bnd  = 1'b0;
        if (clear) begin
            w_next = C_RST;
        end else if (load) begin
            w_next = f_clamp(load_val);
        end else if (en) begin
            if (up_dn) begin
                if (w_at_top) begin
                    w_bnd  = 1'b1;
                    w_next = C_SAT ? r_count : '0;
                end else begin
                    w_next = r_count + WIDTH'(1);
                end
            end else begin
                if (w_at_bot) begin
                    w_bnd  = 1'b1;
                    w_next = C_SAT ? r_count : C_MAX;
                end else begin
                    w_next = r_count - WIDTH'(1);
                end
            end
        end
    end

    // State update; a boundary event sets ovf even when clr_ovf is asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= C_RST;
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_next;
            r_wrap  <= w_bnd;
            r_ovf   <= w_bnd | (r_ovf & ~clr_ovf);
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;
    assign ovf   = r_ovf;
    // Terminal count looks ahead one edge so it can enable a cascaded stage.
    assign tc    = en & (up_dn ? w_at_top : w_at_bot);

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised synchronous successor to the 4-bit ripple counter. Fully synchronous: every bit is clocked by clk.
- Adds a programmable modulus, up/down direction, parallel load, synchronous clear, and count enable.
- Supports wrap or saturate mode, with terminal-count, wrap-pulse and sticky-overflow status.
- Used as a general event/timer counter in datapath and control blocks.

Parameters:
- WIDTH, 4, counter width in bits (>=1).
- MAX_COUNT, 15, highest count value; the counter runs modulo MAX_COUNT+1. Must satisfy 1 <= MAX_COUNT <= 2^WIDTH-1 (elaboration error otherwise).
- RESET_VALUE, 0, value loaded by rst and by clear. Must be <= MAX_COUNT.
- SATURATE, 0, 0 = wrap at boundaries; 1 = hold at boundaries.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable.
- up_dn  input  1  direction: 1 = up, 0 = down; sampled only when counting.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- clear  input  1  synchronous return to RESET_VALUE.
- clr_ovf  input  1  clears the sticky ovf flag.
- count  output  WIDTH  current count (registered).
- tc  output  1  terminal count (combinational from count, en, up_dn).
- wrap  output  1  one-cycle registered pulse on a boundary event.
- ovf  output  1  sticky boundary-event flag (registered).

Behaviour:
- Reset: when rst=1 at a rising edge, count=RESET_VALUE, wrap=0, ovf=0. rst overrides all other inputs. Reset mid-count takes effect at that edge with no partial update.
- Priority per edge, highest first: rst > clear > load > en. Exactly one action is taken per cycle.
- clear: count<=RESET_VALUE, wrap<=0, ovf unchanged.
- load: count<=min(load_val, MAX_COUNT), i.e. out-of-range values clamp to MAX_COUNT. wrap<=0, ovf unchanged.
- en=1, up_dn=1:
  - count<MAX_COUNT: count+1.
  - count==MAX_COUNT, SATURATE=0: count<=0, wrap<=1.
  - count==MAX_COUNT, SATURATE=1: count holds, wrap<=1.
- en=1, up_dn=0:
  - count>0: count-1.
  - count==0, SATURATE=0: count<=MAX_COUNT, wrap<=1.
  - count==0, SATURATE=1: count holds, wrap<=1.
- en=0 (and no clear/load): count holds, wrap<=0.
- wrap timing: high for exactly the one cycle following the boundary edge, i.e. while count shows the wrapped or held value. Back-to-back boundary events give back-to-back pulses, e.g. saturated with en held high gives wrap high on every cycle.
- ovf:
  - Set on any edge where a boundary event occurs.
  - Cleared by clr_ovf=1 when no boundary event occurs on that edge.
  - Simultaneous set and clr_ovf: set wins.
  - Unaffected by clear and load; cleared only by rst or clr_ovf.
- tc: tc = en & (up_dn ? count==MAX_COUNT : count==0). It is high in the cycle before a boundary event, so it can be cascaded into the en of a next-stage counter.
- Arithmetic: modulo MAX_COUNT+1. No intermediate value outside 0..MAX_COUNT is ever visible on count.
- Direction change: takes effect on the next enabled edge. No dead cycle.

Test Plan:
- WIDTH=4, MAX_COUNT=9, SATURATE=0: rst 2 cycles, then en=1, up_dn=1 for 12 cycles -> count 0,1..9,0,1. tc high while count==9. wrap high exactly one cycle, with count==0. ovf=1 from that cycle on.
- Same config, up_dn=0 from count=0 -> count 9,8,7. wrap pulse with count==9. Then clr_ovf=1 for one cycle -> ovf=0 next cycle.
- SATURATE=1, MAX_COUNT=9: load_val=8, then en=1 up for 4 cycles -> count 8,9,9,9. wrap high on each of the two held cycles. Assert clr_ovf together with a saturation edge -> ovf stays 1.
- Load clamp: MAX_COUNT=9, load_val=14, load=1 -> count=9 next cycle. load_val=3 -> count=3.
- Priority: at count=5, assert clear=1, load=1 (load_val=7), en=1 in the same cycle -> count=RESET_VALUE. Then load=1 with en=1 -> count=7 (no increment).
- Reset mid-operation: counting up at count=6 with ovf=1, assert rst for 1 cycle alongside load and en -> count=RESET_VALUE, wrap=0, ovf=0. Counting resumes from RESET_VALUE on the next cycle.
